// File: rtl/i2c_byte_engine_if.sv
// Handshake and pad-level bus bundle for the I2C byte engine.
// The master modport is the requesting side; the slave modport is the engine.
interface i2c_byte_engine_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] dbl_clock_divisor;
    logic             start;
    logic             rd;
    logic [7:0]       tx_byte;
    logic             ack_out;
    logic             scl_i;
    logic             sda_i;
    logic             scl_o;
    logic             sda_o;
    logic             busy;
    logic             done;
    logic [7:0]       rx_byte;
    logic             ack_rx;

    modport master (
        output dbl_clock_divisor, start, rd, tx_byte, ack_out, scl_i, sda_i,
        input  scl_o, sda_o, busy, done, rx_byte, ack_rx
    );

    modport slave (
        input  dbl_clock_divisor, start, rd, tx_byte, ack_out, scl_i, sda_i,
        output scl_o, sda_o, busy, done, rx_byte, ack_rx
    );
endinterface

// File: rtl/i2c_byte_engine.sv
// I2C master bit engine: shifts 8 data bits (MSB first) plus the ACK bit onto
// SCL/SDA using dbl_clock_divisor half-periods, honouring slave clock stretching.
module i2c_byte_engine #(
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    i2c_byte_engine_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] ctr;
    logic [3:0]       bit_idx;
    logic             rd_q;
    logic [7:0]       tx_q;
    logic             ack_out_q;

    // SDA level driven during the LOW phase of bit idx (idx 8 is the ACK slot).
    function automatic logic low_bit(input logic       rd,
                                     input logic [7:0] tx,
                                     input logic       ack,
                                     input logic [3:0] idx);
        if (idx == 4'd8) return rd ? ack : 1'b1;
        return rd ? 1'b1 : tx[3'd7 - idx[2:0]];
    endfunction

    // NOTE: every register here is state, so all updates are non-blocking;
    // reads within the block see the values from before this clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_q       <= '0;
            ctr         <= '0;
            bit_idx     <= '0;
            rd_q        <= 1'b0;
            tx_q        <= '0;
            ack_out_q   <= 1'b1;
            bus.scl_o   <= 1'b1;
            bus.sda_o   <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rx_byte <= '0;
            bus.ack_rx  <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_q     <= bus.dbl_clock_divisor;
                        rd_q      <= bus.rd;
                        tx_q      <= bus.tx_byte;
                        ack_out_q <= bus.ack_out;
                        bit_idx   <= '0;
                        ctr       <= '0;
                        bus.busy  <= 1'b1;
                        bus.scl_o <= 1'b0;
                        bus.sda_o <= low_bit(bus.rd, bus.tx_byte, bus.ack_out, 4'd0);
                        state     <= LOW;
                    end
                end

                LOW: begin
                    if (ctr == div_q) begin
                        ctr       <= '0;
                        bus.scl_o <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end

                HIGH: begin
                    // A slave holding SCL low freezes the half-period indefinitely.
                    if (bus.scl_i) begin
                        if (ctr == div_q) begin
                            ctr <= '0;
                            if (bit_idx != 4'd8 && rd_q)
                                bus.rx_byte[3'd7 - bit_idx[2:0]] <= bus.sda_i;
                            if (bit_idx == 4'd8 && !rd_q)
                                bus.ack_rx <= bus.sda_i;
                            if (bit_idx == 4'd8) begin
                                bus.done  <= 1'b1;
                                bus.busy  <= 1'b0;
                                bus.scl_o <= 1'b0;
                                bus.sda_o <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                bit_idx   <= bit_idx + 4'd1;
                                bus.scl_o <= 1'b0;
                                bus.sda_o <= low_bit(rd_q, tx_q, ack_out_q, bit_idx + 4'd1);
                                state     <= LOW;
                            end
                        end else begin
                            ctr <= ctr + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Scoreboard bench for i2c_byte_engine: stimulus queues expected byte results,
// a negedge monitor reconstructs SDA per LOW phase and latency and compares at done.
module tb_i2c_byte_engine;

    localparam int DIV_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_byte_engine_if #(.DIV_W(DIV_W)) bus ();
    i2c_byte_engine #(.DIV_W(DIV_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Open-drain pads: the slave model and stretch control can only pull low.
    logic stretch   = 1'b0;
    logic slave_bit = 1'b1;
    assign bus.scl_i = bus.scl_o & ~stretch;
    assign bus.sda_i = bus.sda_o & slave_bit;

    logic       slv_rd   = 1'b0;
    logic [7:0] slv_data = 8'h00;
    logic       slv_ack  = 1'b0;

    typedef struct {
        logic [8:0] pat;
        int         lat;
        logic [7:0] rx;
        logic       ack;
        bit         chk_rx;
        bit         chk_ack;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] pat, input int lat, input logic [7:0] rx,
                                input logic ack, input bit chk_rx, input bit chk_ack);
        exp_t e;
        e.pat = pat; e.lat = lat; e.rx = rx; e.ack = ack;
        e.chk_rx = chk_rx; e.chk_ack = chk_ack;
        return e;
    endfunction

    // Monitor and slave model
    logic       scl_prev  = 1'b1;
    logic       busy_prev = 1'b0;
    int         rise_cnt  = 0;
    int         slave_idx = 0;
    int         lat       = 0;
    logic [8:0] pat       = '1;
    exp_t       cur;

    always @(negedge clk) begin
        if (bus.busy && !busy_prev) begin
            lat = 0;
            pat = '1;
        end else begin
            lat++;
        end
        if (!bus.busy) rise_cnt = 0;
        else if (bus.scl_o && !scl_prev) rise_cnt++;
        if (bus.busy && !bus.scl_o && rise_cnt <= 8) begin
            pat[8 - rise_cnt] = bus.sda_o;
            slave_idx = rise_cnt;
        end
        if (slv_rd) slave_bit = (slave_idx < 8) ? slv_data[7 - slave_idx] : 1'b1;
        else        slave_bit = (slave_idx == 8) ? slv_ack : 1'b1;

        if (bus.done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done, expected no pending byte");
            end else begin
                cur = q.pop_front();
                check("sda_pattern", 32'(pat), 32'(cur.pat));
                check("done_latency", lat, cur.lat);
                if (cur.chk_rx)  check("rx_byte", 32'(bus.rx_byte), 32'(cur.rx));
                if (cur.chk_ack) check("ack_rx", 32'(bus.ack_rx), 32'(cur.ack));
            end
        end
        scl_prev  = bus.scl_o;
        busy_prev = bus.busy;
    end

    task automatic issue(input logic [15:0] d, input logic r, input logic [7:0] tx,
                         input logic ao, input bit push, input exp_t e);
        @(negedge clk);
        bus.dbl_clock_divisor = d;
        bus.rd      = r;
        bus.tx_byte = tx;
        bus.ack_out = ao;
        bus.start   = 1'b1;
        if (push) q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
        check("idle_wait_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic prev;
        exp_t none;
        none = mk('1, 0, 8'h00, 1'b1, 1'b0, 1'b0);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.dbl_clock_divisor = 16'd3;
        bus.rd = 1'b0;
        bus.tx_byte = 8'h00;
        bus.ack_out = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl_o", 32'(bus.scl_o), 32'd1);
        check("rst_sda_o", 32'(bus.sda_o), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx_byte", 32'(bus.rx_byte), 32'd0);
        check("rst_ack_rx", 32'(bus.ack_rx), 32'd1);
        reset = 1'b0;

        // Write A5, slave ACKs
        slv_rd = 1'b0; slv_ack = 1'b0;
        issue(16'd3, 1'b0, 8'hA5, 1'b1, 1'b1, mk(9'b101001011, 72, 8'h00, 1'b0, 1'b0, 1'b1));
        wait_idle(200);

        // Read 3C with NACK, then with ACK
        slv_rd = 1'b1; slv_data = 8'h3C;
        issue(16'd3, 1'b1, 8'h00, 1'b1, 1'b1, mk(9'b111111111, 72, 8'h3C, 1'b0, 1'b1, 1'b0));
        wait_idle(200);
        issue(16'd3, 1'b1, 8'h00, 1'b0, 1'b1, mk(9'b111111110, 72, 8'h3C, 1'b0, 1'b1, 1'b0));
        wait_idle(200);
        check("idle_held_scl_o", 32'(bus.scl_o), 32'd0);
        check("idle_held_sda_o", 32'(bus.sda_o), 32'd1);

        // Write 5A with 10 cycles of stretching at the start of the bit-3 HIGH phase
        slv_rd = 1'b0; slv_ack = 1'b0;
        issue(16'd3, 1'b0, 8'h5A, 1'b1, 1'b1, mk(9'b010110101, 82, 8'h00, 1'b0, 1'b0, 1'b1));
        cnt = 0;
        prev = bus.scl_o;
        for (int i = 0; i < 200 && cnt < 4; i++) begin
            @(negedge clk);
            if (bus.scl_o && !prev) cnt++;
            prev = bus.scl_o;
        end
        check("stretch_sync", cnt, 4);
        stretch = 1'b1;
        repeat (10) @(negedge clk);
        stretch = 1'b0;
        wait_idle(200);

        // D = 0, write FF, slave NACKs
        slv_ack = 1'b1;
        issue(16'd0, 1'b0, 8'hFF, 1'b1, 1'b1, mk(9'b111111111, 18, 8'h00, 1'b1, 1'b0, 1'b1));
        wait_idle(100);

        // Start and divisor change while busy must not disturb the byte
        slv_ack = 1'b0;
        issue(16'd3, 1'b0, 8'hA5, 1'b1, 1'b1, mk(9'b101001011, 72, 8'h00, 1'b0, 1'b0, 1'b1));
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.tx_byte = 8'h00;
        bus.dbl_clock_divisor = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(200);
        issue(16'hFFFF, 1'b0, 8'h81, 1'b1, 1'b0, none);
        repeat (200) @(negedge clk);
        check("long_div_busy", 32'(bus.busy), 32'd1);
        check("long_div_scl_low", 32'(bus.scl_o), 32'd0);
        check("long_div_sda_bit7", 32'(bus.sda_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of bit 4
        issue(16'd3, 1'b0, 8'hA5, 1'b1, 1'b0, none);
        repeat (34) @(negedge clk);
        check("bit4_low_sda", 32'(bus.sda_o), 32'd0);
        check("bit4_low_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_scl_o", 32'(bus.scl_o), 32'd1);
        check("async_rst_sda_o", 32'(bus.sda_o), 32'd1);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(16'd3, 1'b0, 8'hA5, 1'b1, 1'b1, mk(9'b101001011, 72, 8'h00, 1'b0, 1'b0, 1'b1));
        wait_idle(200);

        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
